// File: rtl/sid_multi_sched.sv
// rtl/sid_multi_sched.sv - time-multiplexed voice/filter scheduler for NUM_SIDS SID cores
// Optional feature macro: SID_SCHED_MIX_EN (adds saturating mix_o output)
module sid_multi_sched #(
  parameter int NUM_SIDS   = 2,
  parameter int VOICE_W    = 24,
  parameter int AUDIO_W    = 24,
  parameter int STATE_W    = 64,
  parameter int VOICE_LAT  = 1,
  parameter int FILTER_LAT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          voice_req,
  output logic [1:0]                    voice_sid,
  output logic [1:0]                    voice_no,
  input  logic [VOICE_W-1:0]            voice_o,
  input  logic [7:0]                    osc_o,
  output logic                          filter_start,
  output logic [1:0]                    filter_sid,
  output logic [3*VOICE_W-1:0]          filter_voices,
  output logic [STATE_W-1:0]            filter_state_o,
  input  logic [STATE_W-1:0]            filter_state_i,
  input  logic [AUDIO_W-1:0]            filter_o,
  output logic [8*NUM_SIDS-1:0]         osc3,
  output logic [AUDIO_W*NUM_SIDS-1:0]   audio_o,
  output logic                          audio_valid,
  output logic                          busy,
  output logic                          overrun
`ifdef SID_SCHED_MIX_EN
  ,
  output logic signed [AUDIO_W-1:0]     mix_o
`endif
);

  localparam logic [1:0] LAST_SID = 2'(NUM_SIDS - 1);
  localparam logic [2:0] NSIDS    = 3'(NUM_SIDS);
  localparam logic [3:0] FLAST    = 4'(FILTER_LAT - 1);

  typedef enum logic {IDLE, ISSUE} vstate_t;
  typedef enum logic {FIDLE, FRUN} fstate_t;

  vstate_t vstate, vstate_nxt;
  fstate_t fstate, fstate_nxt;

  logic [1:0] vsid, vno;
  logic       accept;

  // Arrays are sized for the maximum SID count so 2-bit indices always fit.
  logic [VOICE_W-1:0] vreg  [4][3];
  logic [7:0]         osc_r [4];
  logic [STATE_W-1:0] saved [4];
  logic [AUDIO_W-1:0] hold  [4];

  logic [VOICE_LAT-1:0] pv;
  logic [1:0]           ps [VOICE_LAT];
  logic [1:0]           pn [VOICE_LAT];
  logic                 cap_v, cap_v2;
  logic [1:0]           cap_sid, cap_no;
  logic [2:0]           cap_cnt;

  logic [2:0] fk, tgt;
  logic [3:0] fcnt;
  logic       flast, go, load, ready;
  logic [VOICE_W-1:0]          v2_sel;
  logic [AUDIO_W*NUM_SIDS-1:0] audio_nxt;

  // A start pulse coinciding with audio_valid still belongs to the running schedule.
  assign accept = start && !busy && !audio_valid;

  // Voice FSM state register
  always_ff @(posedge clk) begin
    if (rst) vstate <= IDLE;
    else     vstate <= vstate_nxt;
  end

  // Voice FSM next state: issue 3*NUM_SIDS slots back to back
  always_comb begin
    vstate_nxt = vstate;
    case (vstate)
      IDLE:    if (accept) vstate_nxt = ISSUE;
      ISSUE:   if (vsid == LAST_SID && vno == 2'd2) vstate_nxt = IDLE;
      default: vstate_nxt = IDLE;
    endcase
  end

  // Voice FSM outputs: slot indices are forced to 0 outside ISSUE
  always_comb begin
    voice_req = (vstate == ISSUE);
    voice_sid = voice_req ? vsid : 2'd0;
    voice_no  = voice_req ? vno  : 2'd0;
  end

  // Slot counters walk sid-major, voice-minor
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      vsid <= 2'd0;
      vno  <= 2'd0;
    end else if (vstate == ISSUE) begin
      if (vno == 2'd2) begin
        vno  <= 2'd0;
        vsid <= vsid + 2'd1;
      end else begin
        vno <= vno + 2'd1;
      end
    end
  end

  // Tag pipeline tracking which slot's result is on voice_o this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < VOICE_LAT; i++) begin
        ps[i] <= 2'd0;
        pn[i] <= 2'd0;
      end
    end else begin
      pv[0] <= voice_req;
      ps[0] <= voice_sid;
      pn[0] <= voice_no;
      for (int i = 1; i < VOICE_LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pn[i] <= pn[i-1];
      end
    end
  end

  assign cap_v   = pv[VOICE_LAT-1];
  assign cap_sid = ps[VOICE_LAT-1];
  assign cap_no  = pn[VOICE_LAT-1];
  assign cap_v2  = cap_v && (cap_no == 2'd2);

  // Voice result and OSC3 capture
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 4; s++) begin
        osc_r[s] <= 8'd0;
        for (int v = 0; v < 3; v++) vreg[s][v] <= '0;
      end
    end else if (cap_v) begin
      vreg[cap_sid][cap_no] <= voice_o;
      if (cap_no == 2'd2) osc_r[cap_sid] <= osc_o;
    end
  end

  // Per-SID OSC3 readback bus
  always_comb begin
    osc3 = '0;
    for (int i = 0; i < NUM_SIDS; i++) osc3[i*8 +: 8] = osc_r[i];
  end

  // Slot readiness: voice 2 already captured, or being captured now (bypassed)
  always_comb begin
    flast  = (fstate == FRUN) && (fcnt == FLAST);
    tgt    = (fstate == FRUN) ? fk + 3'd1 : fk;
    ready  = (cap_cnt > tgt) || (cap_v2 && ({1'b0, cap_sid} == tgt));
    go     = busy && (tgt < NSIDS) && ready;
    load   = go && ((fstate == FIDLE) || flast);
    v2_sel = (cap_v2 && cap_sid == tgt[1:0]) ? voice_o : vreg[tgt[1:0]][2];
  end

  // Filter FSM state register
  always_ff @(posedge clk) begin
    if (rst) fstate <= FIDLE;
    else     fstate <= fstate_nxt;
  end

  // Filter FSM next state: slots chain back to back when the next SID is ready
  always_comb begin
    fstate_nxt = fstate;
    case (fstate)
      FIDLE:   if (go) fstate_nxt = FRUN;
      FRUN:    if (flast) fstate_nxt = go ? FRUN : FIDLE;
      default: fstate_nxt = FIDLE;
    endcase
  end

  // Filter FSM outputs
  always_comb begin
    filter_start = (fstate == FRUN) && (fcnt == 4'd0);
  end

  // Final published audio: last SID comes straight from the filter this cycle
  always_comb begin
    audio_nxt = '0;
    for (int i = 0; i < NUM_SIDS; i++)
      audio_nxt[i*AUDIO_W +: AUDIO_W] = (i == NUM_SIDS - 1) ? filter_o : hold[i];
  end

  // Schedule bookkeeping, filter slot registers, state save/restore, audio publish
  always_ff @(posedge clk) begin
    if (rst) begin
      busy           <= 1'b0;
      overrun        <= 1'b0;
      audio_valid    <= 1'b0;
      audio_o        <= '0;
      fk             <= 3'd0;
      fcnt           <= 4'd0;
      cap_cnt        <= 3'd0;
      filter_sid     <= 2'd0;
      filter_voices  <= '0;
      filter_state_o <= '0;
      for (int s = 0; s < 4; s++) begin
        saved[s] <= '0;
        hold[s]  <= '0;
      end
    end else begin
      audio_valid <= 1'b0;
      if (start && (busy || audio_valid)) overrun <= 1'b1;
      if (accept) begin
        busy    <= 1'b1;
        fk      <= 3'd0;
        cap_cnt <= 3'd0;
      end
      if (cap_v2) cap_cnt <= cap_cnt + 3'd1;
      if (load)                fcnt <= 4'd0;
      else if (fstate == FRUN) fcnt <= fcnt + 4'd1;
      if (flast) begin
        saved[fk[1:0]] <= filter_state_i;
        hold[fk[1:0]]  <= filter_o;
        fk             <= fk + 3'd1;
        if (fk == NSIDS - 3'd1) begin
          audio_valid <= 1'b1;
          busy        <= 1'b0;
          audio_o     <= audio_nxt;
        end
      end
      if (load) begin
        filter_sid     <= tgt[1:0];
        filter_voices  <= {v2_sel, vreg[tgt[1:0]][1], vreg[tgt[1:0]][0]};
        filter_state_o <= saved[tgt[1:0]];
      end
    end
  end

`ifdef SID_SCHED_MIX_EN
  localparam logic signed [AUDIO_W+1:0] MIX_MAX = $signed({3'b000, {(AUDIO_W-1){1'b1}}});
  localparam logic signed [AUDIO_W+1:0] MIX_MIN = $signed({3'b111, {(AUDIO_W-1){1'b0}}});
  logic signed [AUDIO_W+1:0] msum;
  logic        [AUDIO_W-1:0] mix_nxt;

  // Saturating sum of all channels being published
  always_comb begin
    msum = '0;
    for (int i = 0; i < NUM_SIDS; i++)
      msum = msum + $signed({{2{audio_nxt[i*AUDIO_W + AUDIO_W - 1]}}, audio_nxt[i*AUDIO_W +: AUDIO_W]});
    if (msum > MIX_MAX)      mix_nxt = MIX_MAX[AUDIO_W-1:0];
    else if (msum < MIX_MIN) mix_nxt = MIX_MIN[AUDIO_W-1:0];
    else                     mix_nxt = msum[AUDIO_W-1:0];
  end

  // Mix register updates alongside audio_o
  always_ff @(posedge clk) begin
    if (rst) mix_o <= '0;
    else if (flast && fk == NSIDS - 3'd1) mix_o <= $signed(mix_nxt);
  end
`endif

endmodule

// File: doc/sid_multi_sched.md
Name: sid_multi_sched

Overview:
- Parametrised time-multiplex scheduler for NUM_SIDS SID cores sharing one voice pipeline (sid_voice) and one filter pipeline (sid_filter).
- On each SID cycle start pulse, issues every voice slot (3 per SID) to the voice pipeline and captures voice/OSC3 results.
- Runs the filter once per SID, serialised, while saving and restoring each SID's filter state.
- Publishes all audio outputs together with a one-cycle valid strobe; the generalised successor of the fixed two-SID sequencing in the top level.

Parameters:
NUM_SIDS, 2, number of SID cores scheduled (1..4)
VOICE_W, 24, voice pipeline output width
AUDIO_W, 24, signed filter audio output width
STATE_W, 64, filter state vector width
VOICE_LAT, 1, voice pipeline latency in cycles (1..3)
FILTER_LAT, 8, filter pipeline latency; filter slot length in cycles (4..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  SID cycle start pulse (phase PHI1_PHI2)
voice_req  out  1  voice slot issued this cycle
voice_sid  out  2  SID index of issued slot
voice_no  out  2  voice index 0..2 of issued slot
voice_o  in  VOICE_W  voice pipeline result
osc_o  in  8  voice pipeline oscillator MSBs
filter_start  out  1  filter slot begins (filter stage 0)
filter_sid  out  2  SID index of current filter slot
filter_voices  out  3*VOICE_W  captured voices {v3,v2,v1} for filter_sid
filter_state_o  out  STATE_W  saved state presented to filter
filter_state_i  in  STATE_W  state returned by filter
filter_o  in  AUDIO_W  filter audio result
osc3  out  8*NUM_SIDS  per-SID OSC3 readback
audio_o  out  AUDIO_W*NUM_SIDS  per-SID audio, index 0 in LSBs
audio_valid  out  1  one-cycle strobe: audio_o updated
busy  out  1  schedule in progress
overrun  out  1  sticky: start arrived while busy

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, saved filter states 0, state IDLE.
- Voice FSM states: IDLE -> ISSUE.
  - IDLE: on start, go to ISSUE.
  - ISSUE: one slot per cycle, ordered sid 0 v0,v1,v2, then sid 1, and so on; 3*NUM_SIDS cycles total, with voice_req=1 throughout. Then return to IDLE.
- Capture: the slot issued at cycle t has its result in voice_o at t+VOICE_LAT, stored into voice register [sid][no]. For voice 2, osc_o is stored into osc3[sid] in the same cycle.
- Filter FSM states: FIDLE -> FRUN.
  - Filter slot k may start only after SID k's voice 2 is captured and slot k-1 has ended.
  - FRUN lasts FILTER_LAT cycles. filter_start pulses in the first cycle.
  - filter_sid, filter_voices and filter_state_o are registered and held stable for the whole slot.
  - In the final cycle of the slot: saved_state[k] <= filter_state_i and audio_hold[k] <= filter_o.
- End of schedule: after the final cycle of the last slot, audio_o <= all audio_hold in one cycle and audio_valid=1 for that single cycle. busy falls in the same cycle.
- busy is 1 from the cycle after start is accepted until audio_valid.
- Start while busy: ignored, schedule unaffected, overrun set to 1. overrun is cleared only by rst.
- start coincident with audio_valid counts as busy: it is ignored and sets overrun.
- NUM_SIDS=1 edge case: 3 voice cycles, then 1 filter slot.
- Reset mid-schedule: FSMs go to IDLE and saved states are cleared. No audio_valid is generated.
- Total latency, start to audio_valid = 1 + max(3*NUM_SIDS + VOICE_LAT, 3 + VOICE_LAT + NUM_SIDS*FILTER_LAT) cycles.
- Unused upper index bits of voice_sid and filter_sid are 0.

Optional Feature:
SID_SCHED_MIX_EN
- Defined: adds output mix_o (AUDIO_W, signed). mix_o is the saturating sum of all audio_o channels and updates in the same cycle as audio_o. It clamps to the max/min of the signed AUDIO_W range.
- Undefined: no mix_o port and no adder logic.

Test Plan:
- Reset, then one start with NUM_SIDS=2, VOICE_LAT=1, FILTER_LAT=8 -> voice_req high for exactly 6 cycles in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); filter_start pulses at cycles 5 and 13 after start; audio_valid at cycle 21.
- voice_o = 0x100*sid + no echoed with 1-cycle lag -> filter_voices for sid1 = {0x102,0x101,0x100}; osc3 = {osc for sid1 v2, osc for sid0 v2}.
- filter_state_i = 0xA in slot 0 and 0xB in slot 1 -> on the next schedule, filter_state_o shows 0xA in slot 0 and 0xB in slot 1.
- start pulsed again 4 cycles after the first start -> schedule unchanged; overrun=1 and stays 1 until rst.
- rst asserted mid-filter slot, then start -> no stale audio_valid; filter_state_o=0 in slot 0.
- SID_SCHED_MIX_EN with filter_o 0x7FFFFF for both channels -> mix_o=0x7FFFFF (saturated). With 0x000010 and 0xFFFFF0 -> mix_o=0.
